// File: rtl/hazard_unit.sv
// Purpose: pipeline hazard control. It forwards EX operands, stalls on load-use,
//          flushes on taken branches and holds the pipe for multi-cycle ops.
// Latency: the forward, stall and flush outputs are combinational. McDone and
//          StallCnt are registered, and McBusy comes straight from the state flop.
// Backpressure: while a multi-cycle op occupies EX, F/D/E are held and a bubble
//          goes to MEM. A load-use hazard holds F/D and inserts an E bubble.
// Ports: clk, rst (async active-low); Rs1D/Rs2D decode sources; Rs1E/Rs2E/RdE
//        execute regs; RdM/RdW with RegWriteM/RegWriteW; ResultSrcE (01=load);
//        PCSrcE taken branch; McStartE multi-cycle start; ForwardAE/BE selects;
//        Stall*/Flush* pipeline controls; McBusy, McDone, StallCnt status.
module hazard_unit #(
  parameter int MC_LAT    = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic [4:0]           RdM,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic [1:0]           ResultSrcE,
  input  logic                 PCSrcE,
  input  logic                 McStartE,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushM,
  output logic                 McBusy,
  output logic                 McDone,
  output logic [CNT_WIDTH-1:0] StallCnt
);

  typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} state_t;

  // Loading MC_LAT-2 gives MC_LAT-1 cycles in MC_WAIT. Together with the
  // cycle in which McStartE is seen, the op occupies EX for MC_LAT cycles.
  localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 2);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 mc_done_q, mc_done_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                 lw_stall;

  // Memory has priority over Writeback. x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic wr_m,
                                         input logic [4:0] rd_w, input logic wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))      return 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mc_done_d = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    case (state_q)
      RUN: begin
        if (McStartE) begin
          state_d = MC_WAIT;
          cnt_d   = MC_LOAD;
        end
        // A multi-cycle start wins over a branch in the same cycle. Decode
        // never issues both, so PCSrcE is simply masked here.
        if (PCSrcE && !McStartE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (lw_stall) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      MC_WAIT: begin
        // Freeze the front of the pipe and send bubbles into MEM. Branch and
        // load-use conditions cannot change while EX is held.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d   = RUN;
          mc_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Stall-cycle counter that saturates at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallF && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      mc_done_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mc_done_q   <= mc_done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign McBusy   = (state_q == MC_WAIT);
  assign McDone   = mc_done_q;
  assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Purpose: self-checking bench for hazard_unit, using a default instance and a
//          second instance with a 4-bit stall counter for the saturation case.
// Latency: inputs are driven 1ns after the rising edge. Combinational outputs
//          are checked after settling, and registered outputs after the next edge.
// Backpressure: not applicable; all stimulus is directed.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, PCSrcE, McStartE;
  logic [1:0] ResultSrcE;

  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy, McDone;
  logic [15:0] StallCnt;

  logic [1:0]  s_fa, s_fb;
  logic        s_sf, s_sd, s_se, s_fd, s_fe, s_fm, s_busy, s_done;
  logic [3:0]  s_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt;

  always #5 clk = ~clk;

  hazard_unit #(.MC_LAT(4), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .McStartE(McStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .McBusy(McBusy), .McDone(McDone), .StallCnt(StallCnt));

  hazard_unit #(.MC_LAT(4), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .McStartE(McStartE),
    .ForwardAE(s_fa), .ForwardBE(s_fb), .StallF(s_sf), .StallD(s_sd),
    .StallE(s_se), .FlushD(s_fd), .FlushE(s_fe), .FlushM(s_fm),
    .McBusy(s_busy), .McDone(s_done), .StallCnt(s_cnt));

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww;
    logic [1:0] rse;
    logic       pcs;
    logic [1:0] efa, efb;
    logic [5:0] ectl; // {StallF,StallD,StallE,FlushD,FlushE,FlushM}
  } vec_t;

  vec_t vecs[14];

  // Decode never issues a multi-cycle op and a taken branch together.
  always @(negedge clk)
    if (rst && McStartE && PCSrcE) begin
      $display("FAIL exclusivity: McStartE and PCSrcE both high at %0t", $time);
      bad++;
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0; McStartE = 0;
  endtask

  function automatic logic [5:0] ctl();
    return {StallF, StallD, StallE, FlushD, FlushE, FlushM};
  endfunction

  initial begin
    //        rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rse pcs efa efb ectl
    vecs[0]  = '{0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 2, 0, 6'b000000};
    vecs[1]  = '{0, 0, 5, 0, 0, 5, 5, 0, 1, 0, 0, 1, 0, 6'b000000};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 6'b000000};
    vecs[3]  = '{0, 0, 4, 3, 0, 3, 3, 1, 1, 0, 0, 0, 2, 6'b000000};
    vecs[4]  = '{0, 0, 4, 9, 0, 9, 9, 0, 1, 0, 0, 0, 1, 6'b000000};
    vecs[5]  = '{0, 0, 9, 9, 0, 9, 4, 1, 1, 0, 0, 2, 2, 6'b000000};
    vecs[6]  = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, 6'b110010};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b000000};
    vecs[8]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000110};
    vecs[10] = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0, 0, 6'b000110};
    vecs[11] = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 2, 0, 0, 0, 6'b000000};
    vecs[12] = '{7, 0, 2, 2, 7, 2, 2, 1, 1, 1, 0, 2, 2, 6'b110010};
    vecs[13] = '{0, 0, 6, 6, 0, 6, 6, 0, 1, 0, 0, 1, 1, 6'b000000};

    clr();
    rst = 1'b0;
    #12;
    chk("reset_busy", 32'(McBusy), 0);
    chk("reset_done", 32'(McDone), 0);
    chk("reset_cnt", 32'(StallCnt), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_cnt = 0;

    // Combinational vectors in RUN, one clock each, with the stall counter tracked
    for (int i = 0; i < 14; i++) begin
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e;
      Rs2E = vecs[i].rs2e; RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
      RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
      ResultSrcE = vecs[i].rse; PCSrcE = vecs[i].pcs; McStartE = 1'b0;
      #1;
      chk($sformatf("vec%0d_fwdA", i), 32'(ForwardAE), 32'(vecs[i].efa));
      chk($sformatf("vec%0d_fwdB", i), 32'(ForwardBE), 32'(vecs[i].efb));
      chk($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].ectl));
      exp_cnt += int'(vecs[i].ectl[5]);
      cyc();
      chk($sformatf("vec%0d_cnt", i), 32'(StallCnt), 32'(exp_cnt));
    end

    // Multi-cycle op: McStartE at t, busy t+1..t+3, done at t+4
    clr();
    McStartE = 1'b1;
    Rs1E = 5; RdM = 5; RegWriteM = 1'b1;
    #1;
    chk("mc_t_ctl", 32'(ctl()), 0);
    chk("mc_t_busy", 32'(McBusy), 0);
    cyc();
    McStartE = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (k == 2) begin
        PCSrcE = 1'b1;
        ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
        McStartE = 1'b0;
      end
      #1;
      chk($sformatf("mc_t%0d_busy", k), 32'(McBusy), 1);
      chk($sformatf("mc_t%0d_ctl", k), 32'(ctl()), 32'(6'b111001));
      chk($sformatf("mc_t%0d_done", k), 32'(McDone), 0);
      chk($sformatf("mc_t%0d_fwdA", k), 32'(ForwardAE), 2);
      cyc();
      PCSrcE = 1'b0; ResultSrcE = 2'b00; RdE = 0; Rs1D = 0;
    end
    #1;
    chk("mc_t4_busy", 32'(McBusy), 0);
    chk("mc_t4_done", 32'(McDone), 1);
    exp_cnt += 3;
    chk("mc_t4_cnt", 32'(StallCnt), 32'(exp_cnt));
    cyc();
    chk("mc_t5_done", 32'(McDone), 0);

    // McStartE is ignored while an op is already in MC_WAIT
    McStartE = 1'b1;
    cyc();
    McStartE = 1'b1;
    cyc();
    McStartE = 1'b0;
    cyc();
    cyc();
    chk("mc_restart_busy_t4", 32'(McBusy), 0);
    chk("mc_restart_done_t4", 32'(McDone), 1);
    cyc();
    exp_cnt += 3;
    chk("mc_restart_cnt", 32'(StallCnt), 32'(exp_cnt));

    // Reset abort at t+2 of an op
    clr();
    McStartE = 1'b1;
    cyc();
    McStartE = 1'b0;
    cyc();
    chk("abort_pre_busy", 32'(McBusy), 1);
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(McBusy), 0);
    chk("abort_cnt", 32'(StallCnt), 0);
    chk("abort_stallF", 32'(StallF), 0);
    cyc();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("abort_nodone%0d", k), 32'(McDone), 0);
    end

    // Saturation: lwStall held for 20 cycles, small counter pins at 15
    rst = 1'b0;
    #1;
    rst = 1'b1;
    ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
    repeat (20) cyc();
    chk("sat_cnt", 32'(s_cnt), 15);
    chk("wide_cnt", 32'(StallCnt), 20);
    cyc();
    chk("sat_hold", 32'(s_cnt), 15);
    clr();
    cyc();
    chk("sat_idle", 32'(s_cnt), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter: MC_LAT, default 4; total EX-stage occupancy in cycles of a multi-cycle op; legal range 2..16.
REQ-002 Parameter: CNT_WIDTH, default 16; width of the stall performance counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 Rs1D, Rs2D  in  5 each  source register indices of the instruction in Decode.
REQ-006 Rs1E, Rs2E, RdE  in  5 each  source and destination indices of the instruction in Execute.
REQ-007 RdM, RdW  in  5 each  destination indices of the instructions in Memory and Writeback.
REQ-008 RegWriteM, RegWriteW  in  1 each  register-write enables of the Memory and Writeback stages.
REQ-009 ResultSrcE  in  2  result select in Execute; 2'b01 = load.
REQ-010 PCSrcE  in  1  taken branch or jump resolved in Execute.
REQ-011 McStartE  in  1  a multi-cycle ALU op entered Execute this cycle.
REQ-012 ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
REQ-013 StallF, StallD, StallE  out  1 each  hold the PC, IF/ID and ID/EX registers.
REQ-014 FlushD, FlushE, FlushM  out  1 each  clear IF/ID, ID/EX and EX/MEM to a bubble.
REQ-015 McBusy  out  1  high while the FSM is in MC_WAIT.
REQ-016 McDone  out  1  registered one-cycle pulse when a multi-cycle op completes.
REQ-017 StallCnt  out  CNT_WIDTH  count of cycles in which StallF was high.

Function
REQ-018 Forwarding is combinational.
- ForwardAE = 10 if RegWriteM, RdM != 0 and RdM == Rs1E.
- Otherwise ForwardAE = 01 if RegWriteW, RdW != 0 and RdW == Rs1E.
- Otherwise ForwardAE = 00.
- Memory has priority over Writeback.
REQ-019 ForwardBE follows the identical rule using Rs2E.
REQ-020 lwStall = (ResultSrcE == 01) and RdE != 0 and (RdE == Rs1D or RdE == Rs2D).
REQ-021 The FSM has two states, RUN and MC_WAIT, and a 4-bit down-counter.
REQ-022 In RUN with McStartE = 1, the next state is MC_WAIT and the counter loads MC_LAT-2.
REQ-023 In MC_WAIT with counter != 0, the counter decrements and the state holds.
REQ-024 In MC_WAIT with counter == 0, the next state is RUN and McDone = 1 in the following cycle.
REQ-025 Outputs in MC_WAIT:
- StallF = StallD = StallE = 1 and FlushM = 1.
- FlushD = FlushE = 0.
- PCSrcE and lwStall are ignored.
REQ-026 Outputs in RUN with PCSrcE = 1:
- FlushD = FlushE = 1 and all stalls = 0.
- The branch overrides lwStall.
REQ-027 Outputs in RUN with PCSrcE = 0 and lwStall = 1:
- StallF = StallD = 1 and FlushE = 1.
- StallE = 0 and FlushM = 0.
REQ-028 In RUN, all other stall and flush outputs are 0.
REQ-029 McStartE together with PCSrcE in RUN: McStartE is honoured and PCSrcE is ignored. Decode guarantees exclusivity; the bench asserts it.
REQ-030 McStartE while already in MC_WAIT is ignored.
REQ-031 Occupancy: the EX stall lasts exactly MC_LAT-1 cycles, from the cycle after McStartE through the cycle of the count == 0 transition.
REQ-032 StallCnt increments by 1 each cycle StallF = 1 and saturates at all-ones with no wrap.
REQ-033 McBusy is derived directly from the state register.
REQ-034 The forwarding outputs are valid in every state.

Reset
REQ-035 On rst low, immediately and independent of clk:
- state = RUN, counter = 0, McDone = 0, StallCnt = 0.
- McBusy therefore reads 0.
REQ-036 Reset asserted mid MC_WAIT aborts the op, with no McDone pulse.
REQ-037 After reset, combinational outputs follow only the inputs.
REQ-038 Deassertion of rst is synchronised externally; the block needs no extra cycle before accepting McStartE.

Verification
REQ-039 Forwarding with RdM = RdW = Rs1E = 5 and RegWriteM = RegWriteW = 1 -> ForwardAE = 10. Then RegWriteM = 0 -> 01. Then Rs1E = 0 with all Rd = 0 -> 00.
REQ-040 Load-use with ResultSrcE = 01, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1 for that cycle and StallCnt increments by 1. With RdE = 0 -> no stall.
REQ-041 Multi-cycle op with MC_LAT = 4 and McStartE pulsed at cycle t:
- McBusy, StallE and FlushM are high on cycles t+1..t+3.
- McDone is high on cycle t+4.
- StallCnt increases by 3.
REQ-042 Priority in RUN: lwStall and PCSrcE both asserted -> FlushD = FlushE = 1 and StallF = 0. In MC_WAIT: PCSrcE = 1 -> no flush of D or E.
REQ-043 Reset abort: rst low at t+2 of a multi-cycle op -> McBusy = 0 and StallCnt = 0 immediately, and McDone never pulses.
REQ-044 Saturation with CNT_WIDTH = 4: hold lwStall for 20 cycles -> StallCnt = 15 and stays at 15.
